// File: rtl/npu_cq_fetch.sv
// Command-queue fetch engine: walks descriptors from cq_head up to the producer
// tail, issues DMA requests for copy descriptors and raises IRQ pulses.
module npu_cq_fetch #(
  parameter int unsigned DESC_BYTES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  cq_base,
  input  logic [31:0]  cq_size,
  input  logic [31:0]  cq_tail,
  input  logic         doorbell,
  input  logic         head_clr,
  output logic [63:0]  cq_mem_addr,
  input  logic [255:0] cq_mem_rdata,
  output logic         dma_req_valid,
  output logic [63:0]  dma_req_src,
  output logic [63:0]  dma_req_dst,
  output logic [31:0]  dma_req_bytes,
  input  logic         dma_req_ready,
  input  logic         dma_resp_done,
  output logic [31:0]  cq_head,
  output logic         evt_pulse,
  output logic         empty_pulse,
  output logic         err_pulse,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, DMA_REQ, DMA_WAIT, ADVANCE
  } state_t;

  localparam logic [31:0] STRIDE = 32'(DESC_BYTES);

  state_t      state;
  logic        pending;
  logic        evt_q;

  logic [31:0] eff_tail;
  logic [32:0] head_inc;
  logic [31:0] head_next;
  logic [31:0] head_idle;

  logic [7:0]  op;
  logic        evt;
  logic        op_valid;
  logic [63:0] src;
  logic [63:0] dst;
  logic [31:0] len;
  logic        rdata_unused;

  assign eff_tail  = cq_tail & ~(STRIDE - 32'd1);
  // 33-bit sum so a head near 2^32 cannot alias past cq_size
  assign head_inc  = {1'b0, cq_head} + {1'b0, STRIDE};
  assign head_next = (head_inc >= {1'b0, cq_size}) ? '0 : head_inc[31:0];
  assign head_idle = head_clr ? '0 : cq_head;

  assign op       = cq_mem_rdata[7:0];
  assign evt      = cq_mem_rdata[16];
  assign src      = cq_mem_rdata[127:64];
  assign dst      = cq_mem_rdata[191:128];
  assign len      = cq_mem_rdata[223:192];
  assign op_valid = (op == 8'h00) || (op == 8'h01);

  assign rdata_unused = ^{cq_mem_rdata[15:8], cq_mem_rdata[23:17],
                          cq_mem_rdata[63:24], cq_mem_rdata[255:224]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pending       <= 1'b0;
      evt_q         <= 1'b0;
      cq_head       <= '0;
      cq_mem_addr   <= '0;
      dma_req_valid <= 1'b0;
      dma_req_src   <= '0;
      dma_req_dst   <= '0;
      dma_req_bytes <= '0;
      evt_pulse     <= 1'b0;
      empty_pulse   <= 1'b0;
      err_pulse     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      evt_pulse   <= 1'b0;
      empty_pulse <= 1'b0;
      err_pulse   <= 1'b0;
      // Doorbells outside IDLE are remembered; IDLE below consumes them.
      if (doorbell) pending <= 1'b1;

      case (state)
        IDLE: begin
          cq_head <= head_idle;
          if (pending || doorbell) begin
            pending <= 1'b0;
            if (head_idle != eff_tail) begin
              state       <= FETCH;
              busy        <= 1'b1;
              cq_mem_addr <= cq_base + {32'b0, head_idle};
            end else begin
              empty_pulse <= 1'b1;
            end
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          evt_q         <= evt && op_valid;
          dma_req_src   <= src;
          dma_req_dst   <= dst;
          dma_req_bytes <= len;
          if (op == 8'h01 && len != '0) begin
            state         <= DMA_REQ;
            dma_req_valid <= 1'b1;
          end else begin
            state     <= ADVANCE;
            evt_pulse <= evt && op_valid;
            err_pulse <= !op_valid;
          end
        end
        DMA_REQ: begin
          if (dma_req_ready) begin
            dma_req_valid <= 1'b0;
            state         <= DMA_WAIT;
          end
        end
        DMA_WAIT: begin
          if (dma_resp_done) begin
            state     <= ADVANCE;
            evt_pulse <= evt_q;
          end
        end
        ADVANCE: begin
          cq_head <= head_next;
          if (head_next != eff_tail) begin
            state       <= FETCH;
            cq_mem_addr <= cq_base + {32'b0, head_next};
          end else begin
            state       <= IDLE;
            busy        <= 1'b0;
            empty_pulse <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          dma_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
